prio_arbiter: RTL

Parametrised, registered priority arbiter for N request lines with a valid/ready grant handshake. It selects the winner by fixed priority (highest index wins) or by round-robin. The selected grant is held stable until the consumer accepts it. It generalises the team's 8-input registered priority encoder: the width is a parameter, requests pending at a grant are served fairly in round-robin mode, and each grant is a transaction rather than a value re-encoded every cycle.

---
 rtl/prio_arbiter_if.sv | 32 +++
 rtl/prio_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/prio_arbiter_if.sv
// Request/grant bundle between requesters, the arbiter and the grant consumer.
// The master modport is the arbiter side; slave is the requester/consumer side.
interface prio_arbiter_if #(
    parameter int N = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic          en;
    logic [N-1:0]  req;
    logic          grant_valid;
    logic          grant_ready;
    logic [IW-1:0] grant_idx;
    logic [N-1:0]  grant_onehot;

    modport master (
        input  en,
        input  req,
        input  grant_ready,
        output grant_valid,
        output grant_idx,
        output grant_onehot
    );

    modport slave (
        output en,
        output req,
        output grant_ready,
        input  grant_valid,
        input  grant_idx,
        input  grant_onehot
    );
endinterface

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter, fixed priority (MODE 0) or round-robin (MODE 1).
// One cycle from request to grant; a grant is held until grant_ready, max one grant per 2 cycles.
module prio_arbiter #(
    parameter int N    = 8,
    parameter int MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    prio_arbiter_if.master arb
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  onehot_q, onehot_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] win_idx;
    logic          win_found;

    // Scan downward from ptr, wrapping through N-1, so the first set bit wins.
    always_comb begin : winner_search
        int            pos;
        logic [IW-1:0] cand;
        pos       = 0;
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr_q) - i;
            if (pos < 0) begin
                pos = pos + N;
            end
            cand = IW'(pos);
            if (!win_found && arb.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin : next_state
        state_d  = state_q;
        ptr_d    = ptr_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        case (state_q)
            IDLE: begin
                if (arb.en && win_found) begin
                    state_d  = HOLD;
                    valid_d  = 1'b1;
                    idx_d    = win_idx;
                    onehot_d = N'(1) << win_idx;
                end
            end
            HOLD: begin
                // Request and enable changes are ignored until the consumer takes the grant.
                if (arb.grant_ready) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    idx_d    = '0;
                    onehot_d = '0;
                    if (MODE == 1) begin
                        ptr_d = (idx_q == '0) ? IW'(N - 1) : idx_q - IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= IW'(N - 1);
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
        end
    end

    assign arb.grant_valid  = valid_q;
    assign arb.grant_idx    = idx_q;
    assign arb.grant_onehot = onehot_q;
endmodule
